regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with a per-register pending-write scoreboard. It is the next generation of the single-issue GPR file: N read ports, M write ports, and a saturating counter per register that tracks outstanding writes. The counter lets the dual-issue decode stage stall on RAW hazards without an external scoreboard. It sits between decode/issue (read, issue-mark) and writeback (write, clear).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NRD, 4, number of read ports
- NWR, 2, number of write ports, which is also the number of issue ports
- PEND_W, 2, pending-counter width; max outstanding writes per register = 2**PEND_W-1

Ports:
- clk  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- raddr  in  NRD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NRD*DATA_W  read data
- rbusy  out  NRD  register at raddr[i] has a nonzero pending count
- we  in  NWR  write enables
- waddr  in  NWR*ADDR_W  write addresses
- wdata  in  NWR*DATA_W  write data
- iss_valid  in  NWR  issue request; marks iss_addr as pending a write
- iss_addr  in  NWR*ADDR_W  issue destination addresses
- iss_ready  out  NWR  issue request can be accepted this cycle

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus one PEND_W-bit counter cnt[r] per register.
- Register 0: always reads 0, rbusy is always 0, and writes to it are dropped.
  - An issue to address 0 is always ready and has no effect.
- Write port conflict: if two write ports hit the same address in one cycle, the higher-indexed port wins.
- Issue handshake:
  - An issue is accepted when iss_valid[i] && iss_ready[i].
  - iss_ready[i] = 1 when cnt[iss_addr[i]], plus the number of lower-indexed valid issues to the same address, is below the max.
  - iss_ready is combinational from the current state and iss_valid; it never depends on that cycle's writebacks.
- Counter update each cycle:
  - cnt_next = cnt + (accepted issues to r) - (writes to r with we=1).
  - A write to r when cnt[r]=0 still updates the data, and cnt stays 0; the counter never underflows.
  - An issue and a write to the same r in the same cycle cancel, and cnt is unchanged.
- rbusy[i] = (cnt[raddr[i]] != 0), using the registered count only.
- Reads are combinational from the storage array.
- Reset: all registers read 0, all cnt = 0, all rbusy = 0.
  - iss_ready is 1 wherever iss_valid=0, or where the count is 0 with no more than max-1 lower-indexed same-address issues.
  - A reset arriving mid-operation clears pending counts immediately; in-flight writebacks afterwards are treated as unscoreboarded writes.

## Timing
- Read latency is 0 cycles (combinational address to data).
- A write becomes visible on rdata the cycle after the we edge, unless bypass is enabled (see Configuration).
- A scoreboard change is visible on rbusy/iss_ready the cycle after the edge.
- No back-pressure on writes: we is always accepted.

## Configuration
- REGFILE_BYPASS_EN defined:
  - rdata[i] returns wdata from the highest-indexed write port with we=1 and waddr==raddr[i] (address nonzero) in the same cycle.
  - rbusy[i] is masked to 0 when that forwarding occurs and cnt[raddr[i]]==1.
- Not defined: reads return the stored value only, and rbusy reflects the registered count only.

## Structure
- The shared package holds:
  - the default DATA_W, ADDR_W, PEND_W constants;
  - the zero-register address constant;
  - a typedef for the pending-counter type.
- One natural sub-module: regfile_pend_cnt, a single saturating up/down counter with NWR increment and NWR decrement enables; the top instantiates 2**ADDR_W-1 of them.

## Test plan
- Reset:
  - stimulus: resetn low mid-run after writing r5=0x1234 with cnt[5]=2, then release;
  - required: rdata of r5 = 0, rbusy = 0, and iss_ready[0] = 1 for addr 5.
- Dual write conflict:
  - stimulus: we=2'b11, both ports to r7, wdata0=0xAAAA, wdata1=0x5555;
  - required: the next cycle r7 reads 0x5555.
- Zero register:
  - stimulus: write 0xFFFFFFFF to r0, and issue to r0 three times;
  - required: r0 reads 0, rbusy=0, iss_ready always 1.
- Saturation (PEND_W=2):
  - stimulus: issue r3 three times over three cycles;
  - required: the fourth issue sees iss_ready=0. Two simultaneous issues to r3 at cnt=2 give iss_ready=2'b01.
- Issue/write cancel:
  - stimulus: cnt[9]=1, then issue r9 and write r9=0x42 in the same cycle;
  - required: the next cycle cnt[9]=1, rbusy=1, data=0x42.
- Bypass:
  - with REGFILE_BYPASS_EN: write r12=0xBEEF and read r12 in the same cycle; rdata=0xBEEF, and rbusy=0 when cnt[12] was 1.
  - without the macro: the same stimulus returns the old value and rbusy=1.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_mp_pkg
// Shared constants and types for the multi-port register file with
// pending-write scoreboard.
//   DEF_DATA_W / DEF_ADDR_W / DEF_PEND_W : default parameter values
//   ZERO_ADDR                            : hard-wired zero register address
//   pend_cnt_t                           : pending-counter type at default width
//   pend_max()                           : largest count a PEND_W counter holds
// Optional feature macro used by regfile_mp: REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
package regfile_mp_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_PEND_W = 2;

    localparam logic [DEF_ADDR_W-1:0] ZERO_ADDR = '0;

    typedef logic [DEF_PEND_W-1:0] pend_cnt_t;

    // Saturation point of a pending counter: 2**pend_w - 1 outstanding writes.
    function automatic int pend_max(input int pend_w);
        return (1 << pend_w) - 1;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Bundles the read, writeback and issue signals of regfile_mp.
//   raddr     : NRD read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata     : NRD read data words
//   rbusy     : per read port, register has outstanding writes
//   we/waddr/wdata : NWR writeback ports
//   iss_valid/iss_addr/iss_ready : NWR issue (mark-pending) ports
// Modports:
//   master : decode/issue + writeback side (drives addresses, data, requests)
//   slave  : the register file itself
// -----------------------------------------------------------------------------
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = 4,
    parameter int NWR    = 2
);

    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;
    logic [NRD-1:0]        rbusy;

    logic [NWR-1:0]        we;
    logic [NWR*ADDR_W-1:0] waddr;
    logic [NWR*DATA_W-1:0] wdata;

    logic [NWR-1:0]        iss_valid;
    logic [NWR*ADDR_W-1:0] iss_addr;
    logic [NWR-1:0]        iss_ready;

    modport master (
        output raddr, we, waddr, wdata, iss_valid, iss_addr,
        input  rdata, rbusy, iss_ready
    );

    modport slave (
        input  raddr, we, waddr, wdata, iss_valid, iss_addr,
        output rdata, rbusy, iss_ready
    );

endinterface

// File: rtl/regfile_pend_cnt.sv
// -----------------------------------------------------------------------------
// regfile_pend_cnt
// One pending-write counter: saturating up/down counter with NWR increment
// and NWR decrement enables, evaluated together each cycle.
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset, clears the count
//   i_inc   : one bit per accepted issue targeting this register
//   i_dec   : one bit per writeback targeting this register
//   o_cnt   : registered count
// The count never goes below zero (unscoreboarded writes are harmless) and
// never above 2**PEND_W-1.
// -----------------------------------------------------------------------------
module regfile_pend_cnt
    import regfile_mp_pkg::*;
#(
    parameter int PEND_W = DEF_PEND_W,
    parameter int NWR    = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NWR-1:0]    i_inc,
    input  logic [NWR-1:0]    i_dec,
    output logic [PEND_W-1:0] o_cnt
);

    localparam int MAX_CNT = pend_max(PEND_W);

    logic [PEND_W-1:0] r_cnt;
    logic [PEND_W-1:0] w_cnt_next;
    int                w_sum;

    // NOTE: every variable written here gets a value before any branch, so no
    // path through the block can leave it holding state (no latch).
    always_comb begin
        w_sum = int'(r_cnt);
        for (int j = 0; j < NWR; j++) begin
            w_sum = w_sum + int'(i_inc[j]) - int'(i_dec[j]);
        end

        w_cnt_next = r_cnt;
        if (w_sum < 0) begin
            w_cnt_next = '0;
        end else if (w_sum > MAX_CNT) begin
            w_cnt_next = PEND_W'(MAX_CNT);
        end else begin
            w_cnt_next = PEND_W'(w_sum);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port register file (NRD read, NWR write ports) with a saturating
// pending-write counter per register, used by dual-issue decode to stall on
// RAW hazards.
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset (clears data and all counts)
//   bus     : regfile_mp_if.slave
//             raddr/rdata/rbusy           combinational reads + busy flag
//             we/waddr/wdata              writebacks (decrement count)
//             iss_valid/iss_addr/iss_ready issue marks (increment count)
// Register 0 reads zero, is never busy, ignores writes, and always accepts
// issues without effect.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback
// data to the read ports and mask rbusy when that write retires the last
// pending entry.
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int PEND_W = DEF_PEND_W
) (
    input logic          clk,
    input logic          resetn,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int MAX_CNT = pend_max(PEND_W);
    localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_ADDR);

    // ------------------------------------------------------------------
    // Unpack flat bus vectors into per-port arrays
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_raddr    [NRD];
    logic [ADDR_W-1:0] w_waddr    [NWR];
    logic [DATA_W-1:0] w_wdata    [NWR];
    logic [ADDR_W-1:0] w_iss_addr [NWR];

    for (genvar i = 0; i < NRD; i++) begin : g_rd_unpack
        assign w_raddr[i] = bus.raddr[i*ADDR_W +: ADDR_W];
    end

    for (genvar j = 0; j < NWR; j++) begin : g_wr_unpack
        assign w_waddr[j]    = bus.waddr[j*ADDR_W +: ADDR_W];
        assign w_wdata[j]    = bus.wdata[j*DATA_W +: DATA_W];
        assign w_iss_addr[j] = bus.iss_addr[j*ADDR_W +: ADDR_W];
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: the array is reset because reset must leave every register reading
    // zero; a non-reset array would expose power-up garbage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            // NOTE: ports are visited low to high and the last non-blocking
            // write to an address wins, so the higher-indexed port has priority.
            for (int j = 0; j < NWR; j++) begin
                if (bus.we[j] && (w_waddr[j] != R0)) begin
                    r_mem[w_waddr[j]] <= w_wdata[j];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending counters (register 0 has none and is tied to zero)
    // ------------------------------------------------------------------
    logic [PEND_W-1:0] w_cnt [DEPTH];
    logic [NWR-1:0]    w_iss_acc;

    assign w_cnt[0] = '0;

    // An issue is accepted on handshake; issues to r0 never touch a counter.
    always_comb begin
        w_iss_acc = '0;
        for (int j = 0; j < NWR; j++) begin
            w_iss_acc[j] = bus.iss_valid[j] && bus.iss_ready[j] && (w_iss_addr[j] != R0);
        end
    end

    for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
        logic [NWR-1:0] w_inc;
        logic [NWR-1:0] w_dec;

        always_comb begin
            w_inc = '0;
            w_dec = '0;
            for (int j = 0; j < NWR; j++) begin
                w_inc[j] = w_iss_acc[j] && (w_iss_addr[j] == ADDR_W'(r));
                w_dec[j] = bus.we[j] && (w_waddr[j] == ADDR_W'(r));
            end
        end

        regfile_pend_cnt #(
            .PEND_W (PEND_W),
            .NWR    (NWR)
        ) u_pend_cnt (
            .clk    (clk),
            .resetn (resetn),
            .i_inc  (w_inc),
            .i_dec  (w_dec),
            .o_cnt  (w_cnt[r])
        );
    end

    // ------------------------------------------------------------------
    // Issue readiness: registered count plus lower-indexed valid issues to
    // the same destination must stay below saturation. Writebacks in the
    // same cycle are deliberately ignored to keep this path short.
    // ------------------------------------------------------------------
    int w_occ [NWR];

    always_comb begin
        bus.iss_ready = '0;
        for (int i = 0; i < NWR; i++) begin
            w_occ[i] = int'(w_cnt[w_iss_addr[i]]);
            for (int j = 0; j < i; j++) begin
                if (bus.iss_valid[j] && (w_iss_addr[j] == w_iss_addr[i])) begin
                    w_occ[i] = w_occ[i] + 1;
                end
            end
            bus.iss_ready[i] = (w_iss_addr[i] == R0) || (w_occ[i] < MAX_CNT);
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
    logic [NRD-1:0] w_fwd;
`endif

    always_comb begin
        bus.rdata = '0;
        bus.rbusy = '0;
`ifdef REGFILE_BYPASS_EN
        w_fwd     = '0;
`endif
        for (int i = 0; i < NRD; i++) begin
            if (w_raddr[i] != R0) begin
                bus.rdata[i*DATA_W +: DATA_W] = r_mem[w_raddr[i]];
                bus.rbusy[i] = (w_cnt[w_raddr[i]] != '0);
`ifdef REGFILE_BYPASS_EN
                // Highest-indexed matching write port is visited last and wins.
                for (int j = 0; j < NWR; j++) begin
                    if (bus.we[j] && (w_waddr[j] == w_raddr[i])) begin
                        bus.rdata[i*DATA_W +: DATA_W] = w_wdata[j];
                        w_fwd[i] = 1'b1;
                    end
                end
                // The forwarded write retires the only outstanding entry.
                if (w_fwd[i] && (w_cnt[w_raddr[i]] == PEND_W'(1))) begin
                    bus.rbusy[i] = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed bench for regfile_mp at default parameters (32-bit data, 32
// registers, 4 read ports, 2 write/issue ports, 2-bit pending counters).
// Inputs change one time unit after the rising edge; outputs are compared
// after settling and before the next rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_mp;
    import regfile_mp_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 4;
    localparam int NWR    = 2;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    regfile_mp_if #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NRD    (NRD),
        .NWR    (NWR)
    ) bus ();

    regfile_mp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NRD    (NRD),
        .NWR    (NWR),
        .PEND_W (DEF_PEND_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.raddr     = '0;
        bus.we        = '0;
        bus.waddr     = '0;
        bus.wdata     = '0;
        bus.iss_valid = '0;
        bus.iss_addr  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [ADDR_W-1:0] a);
        bus.raddr[p*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic set_wr(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.we[p]                     = 1'b1;
        bus.waddr[p*ADDR_W +: ADDR_W] = a;
        bus.wdata[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_iss(input int p, input logic [ADDR_W-1:0] a);
        bus.iss_valid[p]                 = 1'b1;
        bus.iss_addr[p*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [DATA_W-1:0] rd(input int p);
        return bus.rdata[p*DATA_W +: DATA_W];
    endfunction

    initial begin
        pend_cnt_t cnt_model;
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        idle();

        // ---------------- Reset state ----------------
        tick();
        tick();
        set_rd(0, 5'd5);
        set_iss(0, 5'd5);
        set_iss(1, 5'd5);
        #1;
        check("reset_rdata_r5", rd(0), 32'h0);
        check("reset_rbusy", {28'h0, bus.rbusy}, 32'h0);
        check("reset_iss_ready", {30'h0, bus.iss_ready}, 32'h3);
        idle();
        resetn = 1'b1;
        tick();

        // ---------------- Zero register ----------------
        set_wr(0, 5'd0, 32'hFFFF_FFFF);
        set_iss(0, 5'd0);
        set_iss(1, 5'd0);
        #1;
        check("r0_iss_ready_1", {30'h0, bus.iss_ready}, 32'h3);
        tick();
        idle();
        set_iss(1, 5'd0);
        #1;
        check("r0_iss_ready_2", {30'h0, bus.iss_ready}, 32'h3);
        tick();
        idle();
        set_rd(0, 5'd0);
        set_rd(3, 5'd0);
        #1;
        check("r0_rdata", rd(0), 32'h0);
        check("r0_rbusy", {28'h0, bus.rbusy}, 32'h0);

        // ---------------- Saturation on r3 ----------------
        idle();
        cnt_model = '0;
        set_iss(0, 5'd3);
        #1;
        check("sat_iss1_ready", {30'h0, bus.iss_ready}, 32'h3);
        tick();
        cnt_model++;
        set_rd(1, 5'd3);
        #1;
        check("sat_r3_busy_cnt1", {31'h0, bus.rbusy[1]}, {31'h0, cnt_model != 0});
        tick();
        cnt_model++;
        idle();
        set_iss(0, 5'd3);
        set_iss(1, 5'd3);
        #1;
        check("sat_dual_cnt2_ready", {30'h0, bus.iss_ready}, 32'h1);
        tick();
        cnt_model++;
        idle();
        set_iss(0, 5'd3);
        set_rd(1, 5'd3);
        #1;
        check("sat_fourth_ready", {31'h0, bus.iss_ready[0]}, 32'h0);
        check("sat_r3_busy", {31'h0, bus.rbusy[1]}, 32'h1);
        tick();
        // drain three outstanding writes, one per cycle
        idle();
        for (int k = 0; k < 3; k++) begin
            set_wr(0, 5'd3, 32'h300 + k);
            tick();
        end
        idle();
        set_rd(1, 5'd3);
        #1;
        check("sat_drained_busy", {31'h0, bus.rbusy[1]}, 32'h0);
        check("sat_drained_data", rd(1), 32'h302);

        // ---------------- Dual write conflict on r7 ----------------
        idle();
        set_wr(0, 5'd7, 32'h0000_AAAA);
        set_wr(1, 5'd7, 32'h0000_5555);
        tick();
        idle();
        set_rd(2, 5'd7);
        #1;
        check("conflict_r7", rd(2), 32'h0000_5555);

        // ---------------- Underflow guard on r20 ----------------
        idle();
        set_wr(1, 5'd20, 32'hCAFE);
        tick();
        idle();
        set_rd(0, 5'd20);
        set_iss(0, 5'd20);
        set_iss(1, 5'd20);
        #1;
        check("uflow_data", rd(0), 32'hCAFE);
        check("uflow_busy", {31'h0, bus.rbusy[0]}, 32'h0);
        check("uflow_iss_ready", {30'h0, bus.iss_ready}, 32'h3);
        tick();
        idle();
        set_rd(0, 5'd20);
        #1;
        check("uflow_busy_after_2iss", {31'h0, bus.rbusy[0]}, 32'h1);

        // ---------------- Issue/write cancel on r9 ----------------
        idle();
        set_iss(1, 5'd9);
        tick();
        idle();
        set_iss(0, 5'd9);
        set_wr(1, 5'd9, 32'h42);
        #1;
        check("cancel_iss_ready", {31'h0, bus.iss_ready[0]}, 32'h1);
        tick();
        idle();
        set_rd(3, 5'd9);
        #1;
        check("cancel_data", rd(3), 32'h42);
        check("cancel_busy", {31'h0, bus.rbusy[3]}, 32'h1);
        set_wr(0, 5'd9, 32'h43);
        tick();
        idle();
        set_rd(3, 5'd9);
        #1;
        check("cancel_cleared_busy", {31'h0, bus.rbusy[3]}, 32'h0);

        // ---------------- Bypass on r12 ----------------
        idle();
        set_wr(0, 5'd12, 32'h1111);
        tick();
        idle();
        set_iss(0, 5'd12);
        tick();
        idle();
        set_wr(1, 5'd12, 32'hBEEF);
        set_rd(2, 5'd12);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_rdata", rd(2), 32'hBEEF);
        check("bypass_rbusy", {31'h0, bus.rbusy[2]}, 32'h0);
`else
        check("bypass_rdata", rd(2), 32'h1111);
        check("bypass_rbusy", {31'h0, bus.rbusy[2]}, 32'h1);
`endif
        tick();
        idle();
        set_rd(2, 5'd12);
        #1;
        check("bypass_after_data", rd(2), 32'hBEEF);
        check("bypass_after_busy", {31'h0, bus.rbusy[2]}, 32'h0);

        // ---------------- Reset mid-run ----------------
        idle();
        set_wr(0, 5'd5, 32'h1234);
        tick();
        idle();
        set_iss(0, 5'd5);
        set_iss(1, 5'd5);
        tick();
        idle();
        set_rd(1, 5'd5);
        #1;
        check("midrst_pre_data", rd(1), 32'h1234);
        check("midrst_pre_busy", {31'h0, bus.rbusy[1]}, 32'h1);
        resetn = 1'b0;
        #1;
        check("midrst_data", rd(1), 32'h0);
        check("midrst_busy", {28'h0, bus.rbusy}, 32'h0);
        tick();
        resetn = 1'b1;
        idle();
        set_rd(1, 5'd5);
        set_iss(0, 5'd5);
        #1;
        check("midrst_iss_ready", {31'h0, bus.iss_ready[0]}, 32'h1);
        idle();
        // late writeback after reset is an unscoreboarded write
        set_wr(1, 5'd5, 32'h77);
        tick();
        idle();
        set_rd(1, 5'd5);
        #1;
        check("midrst_late_wb_data", rd(1), 32'h77);
        check("midrst_late_wb_busy", {31'h0, bus.rbusy[1]}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
